// File: rtl/uart_mike_pkg.sv
// Shared types and defaults for the UART "mike" link controller.
// The state encoding is visible on state_o, so the values are pinned here.
package uart_mike_pkg;

    localparam int unsigned LEN_W_DEF        = 4;
    localparam int unsigned RX_TO_CYCLES_DEF = 1024;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StRxData     = 3'd1,
        StWaitFlgClr = 3'd2,
        StTxLoad     = 3'd3,
        StTxData     = 3'd4,
        StErr        = 3'd5
    } link_state_e;

    // States in which a transmit request is deferred rather than started.
    function automatic logic is_rx_side(link_state_e s);
        return (s == StRxData) || (s == StWaitFlgClr) || (s == StErr);
    endfunction

endpackage

// File: rtl/uart_mike_tmo_cnt.sv
// Saturating cycle counter for the receive-acknowledge timeout.
// CYCLES == 0 disables it: expired never asserts.
module uart_mike_tmo_cnt
    import uart_mike_pkg::*;
#(
    parameter int unsigned CYCLES = RX_TO_CYCLES_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Holds at LAST rather than wrapping if en stays high.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (CYCLES != 0) && en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_mike_link_ctrl.sv
// Half-duplex link controller: sequences TX bursts byte by byte, tracks RX
// completion/acknowledge, and defers transmit requests arriving during RX.
module uart_mike_link_ctrl
    import uart_mike_pkg::*;
#(
    parameter int unsigned LEN_W        = LEN_W_DEF,
    parameter int unsigned RX_TO_CYCLES = RX_TO_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             tx_send,
    input  logic [LEN_W-1:0] tx_len,
    input  logic             tx_byte_done,
    input  logic             tx_abort,
    input  logic             rx_start,
    input  logic             rx_done,
    input  logic             rx_err,
    input  logic             rx_flag_clr,
    input  logic             status_clr,
    output logic             tx_byte_req,
    output logic [LEN_W-1:0] tx_idx,
    output logic             tx_inprg,
    output logic             tx_data_cnt_delete,
    output logic             tx_pend,
    output logic             rx_err_flag,
    output logic             rx_overrun,
    output logic             rx_timeout,
    output logic [2:0]       state_o
);

    link_state_e      state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] pend_len_q, pend_len_d;
    logic             pend_q, pend_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             overrun_set, timeout_set;
    logic             tmo_expired;
    logic             tx_req;

    // Zero-length requests are ignored everywhere; abort suppresses any new request.
    assign tx_req = tx_send && (tx_len != '0) && !tx_abort;

    uart_mike_tmo_cnt #(
        .CYCLES (RX_TO_CYCLES)
    ) u_tmo_cnt (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (state_q != StWaitFlgClr),
        .en      (state_q == StWaitFlgClr),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d            = state_q;
        rem_d              = rem_q;
        idx_d              = idx_q;
        pend_d             = pend_q;
        pend_len_d         = pend_len_q;
        overrun_set        = 1'b0;
        timeout_set        = 1'b0;
        tx_byte_req        = 1'b0;
        tx_data_cnt_delete = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_start) begin
                    state_d = StRxData;
                    if (tx_req && !pend_q) begin
                        pend_d     = 1'b1;
                        pend_len_d = tx_len;
                    end
                end else if (pend_q && !tx_abort) begin
                    state_d = StTxLoad;
                    rem_d   = pend_len_q;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    // A fresh request queues behind the one being started.
                    if (tx_req) begin
                        pend_d     = 1'b1;
                        pend_len_d = tx_len;
                    end
                end else if (tx_req) begin
                    state_d = StTxLoad;
                    rem_d   = tx_len;
                    idx_d   = '0;
                end
            end
            StRxData: begin
                if (rx_err) begin
                    state_d = StErr;
                end else if (rx_done) begin
                    state_d = StWaitFlgClr;
                end
            end
            StWaitFlgClr: begin
                if (rx_flag_clr) begin
                    state_d = StIdle;
                end else if (tmo_expired) begin
                    timeout_set = 1'b1;
                    state_d     = StIdle;
                end
                if (rx_start) begin
                    overrun_set = 1'b1;
                end
            end
            StTxLoad: begin
                tx_byte_req = 1'b1;
                if (tx_abort) begin
                    tx_data_cnt_delete = 1'b1;
                    state_d            = StIdle;
                end else begin
                    state_d = StTxData;
                end
            end
            StTxData: begin
                if (tx_abort) begin
                    tx_data_cnt_delete = 1'b1;
                    state_d            = StIdle;
                end else if (tx_byte_done) begin
                    if (rem_q == LEN_W'(1)) begin
                        tx_data_cnt_delete = 1'b1;
                        state_d            = StIdle;
                    end else begin
                        rem_d   = rem_q - 1'b1;
                        idx_d   = idx_q + 1'b1;
                        state_d = StTxLoad;
                    end
                end
            end
            StErr: begin
                if (rx_flag_clr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (is_rx_side(state_q) && tx_req && !pend_q) begin
            pend_d     = 1'b1;
            pend_len_d = tx_len;
        end
        if (tx_abort) begin
            pend_d = 1'b0;
        end

        // A same-cycle set takes precedence over the software clear.
        overrun_d = overrun_set ? 1'b1 : (status_clr ? 1'b0 : overrun_q);
        timeout_d = timeout_set ? 1'b1 : (status_clr ? 1'b0 : timeout_q);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            pend_len_q <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_len_q <= pend_len_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_inprg    = (state_q == StTxData) && (state_d == StTxData);
    assign tx_idx      = idx_q;
    assign tx_pend     = pend_q;
    assign rx_err_flag = (state_q == StErr);
    assign rx_overrun  = overrun_q;
    assign rx_timeout  = timeout_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_uart_mike_link_ctrl.sv
// Directed bench for uart_mike_link_ctrl: bursts, deferral, abort, RX error,
// acknowledge timeout, maximum length and reset mid-burst.
module tb_uart_mike_link_ctrl;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned TO    = 8;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             tx_send, tx_byte_done, tx_abort;
    logic [LEN_W-1:0] tx_len;
    logic             rx_start, rx_done, rx_err, rx_flag_clr, status_clr;
    logic             tx_byte_req, tx_inprg, tx_data_cnt_delete, tx_pend;
    logic             rx_err_flag, rx_overrun, rx_timeout;
    logic [LEN_W-1:0] tx_idx;
    logic [2:0]       state_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int req_cnt   = 0;
    int del_cnt   = 0;

    uart_mike_link_ctrl #(
        .LEN_W        (LEN_W),
        .RX_TO_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_send            (tx_send),
        .tx_len             (tx_len),
        .tx_byte_done       (tx_byte_done),
        .tx_abort           (tx_abort),
        .rx_start           (rx_start),
        .rx_done            (rx_done),
        .rx_err             (rx_err),
        .rx_flag_clr        (rx_flag_clr),
        .status_clr         (status_clr),
        .tx_byte_req        (tx_byte_req),
        .tx_idx             (tx_idx),
        .tx_inprg           (tx_inprg),
        .tx_data_cnt_delete (tx_data_cnt_delete),
        .tx_pend            (tx_pend),
        .rx_err_flag        (rx_err_flag),
        .rx_overrun         (rx_overrun),
        .rx_timeout         (rx_timeout),
        .state_o            (state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_byte_req === 1'b1) req_cnt++;
        if (tx_data_cnt_delete === 1'b1) del_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [15:0] got, exp;
        #3;
        got = {3'b0, state_o, tx_idx, tx_pend, tx_byte_req, tx_inprg, tx_data_cnt_delete,
               rx_err_flag, rx_overrun, rx_timeout};
        exp = 16'h0;
        total_cnt++;
        if (got !== exp) $display("FAIL reset_outputs: got %h want %h", got, exp);
        else pass_cnt++;
        #5;
        n_rst = 1'b1;
    endtask

    task automatic test_burst3;
        logic [15:0] got, exp;
        int r0, d0;
        r0 = req_cnt;
        d0 = del_cnt;
        step;
        tx_send = 1'b1;
        tx_len  = 4'd3;
        step;
        tx_send = 1'b0;
        tx_len  = 4'd0;
        for (int b = 0; b < 3; b++) begin
            #1;
            got = {8'h0, state_o, tx_byte_req, tx_idx};
            exp = {8'h0, 3'd3, 1'b1, 4'(b)};
            total_cnt++;
            if (got !== exp) $display("FAIL burst3_load b=%0d: got %h want %h", b, got, exp);
            else pass_cnt++;
            step;
            for (int k = 0; k < 4; k++) begin
                #1;
                got = {12'h0, state_o, tx_inprg};
                exp = {12'h0, 3'd4, 1'b1};
                total_cnt++;
                if (got !== exp) $display("FAIL burst3_inprg b=%0d k=%0d: got %h want %h",
                                          b, k, got, exp);
                else pass_cnt++;
                step;
            end
            tx_byte_done = 1'b1;
            #1;
            got = {14'h0, tx_inprg, tx_data_cnt_delete};
            exp = {14'h0, 1'b0, (b == 2)};
            total_cnt++;
            if (got !== exp) $display("FAIL burst3_done b=%0d: got %h want %h", b, got, exp);
            else pass_cnt++;
            step;
            tx_byte_done = 1'b0;
        end
        #1;
        got = {req_cnt - r0 == 3, del_cnt - d0 == 1, 11'h0, state_o};
        exp = {1'b1, 1'b1, 11'h0, 3'd0};
        total_cnt++;
        if (got !== exp) $display("FAIL burst3_end: got %h want %h (req=%0d del=%0d)",
                                  got, exp, req_cnt - r0, del_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_pend;
        logic [15:0] got, exp;
        step;
        rx_start = 1'b1;
        tx_send  = 1'b1;
        tx_len   = 4'd2;
        step;
        rx_start = 1'b0;
        tx_send  = 1'b0;
        tx_len   = 4'd0;
        #1;
        got = {12'h0, state_o, tx_pend};
        exp = {12'h0, 3'd1, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL pend_rx: got %h want %h", got, exp);
        else pass_cnt++;
        rx_done = 1'b1;
        step;
        rx_done = 1'b0;
        #1;
        got = {12'h0, state_o, tx_pend};
        exp = {12'h0, 3'd2, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL pend_wait: got %h want %h", got, exp);
        else pass_cnt++;
        rx_flag_clr = 1'b1;
        step;
        rx_flag_clr = 1'b0;
        #1;
        got = {12'h0, state_o, tx_pend};
        exp = {12'h0, 3'd0, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL pend_idle: got %h want %h", got, exp);
        else pass_cnt++;
        step;
        #1;
        got = {7'h0, state_o, tx_pend, tx_byte_req, tx_idx};
        exp = {7'h0, 3'd3, 1'b0, 1'b1, 4'd0};
        total_cnt++;
        if (got !== exp) $display("FAIL pend_load0: got %h want %h", got, exp);
        else pass_cnt++;
        step;
        tx_byte_done = 1'b1;
        #1;
        got = {12'h0, state_o, tx_data_cnt_delete};
        exp = {12'h0, 3'd4, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL pend_byte0: got %h want %h", got, exp);
        else pass_cnt++;
        step;
        tx_byte_done = 1'b0;
        #1;
        got = {8'h0, state_o, tx_byte_req, tx_idx};
        exp = {8'h0, 3'd3, 1'b1, 4'd1};
        total_cnt++;
        if (got !== exp) $display("FAIL pend_load1: got %h want %h", got, exp);
        else pass_cnt++;
        step;
        tx_byte_done = 1'b1;
        #1;
        got = {12'h0, state_o, tx_data_cnt_delete};
        exp = {12'h0, 3'd4, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL pend_byte1: got %h want %h", got, exp);
        else pass_cnt++;
        step;
        tx_byte_done = 1'b0;
        #1;
        got = {12'h0, state_o, tx_pend};
        exp = {12'h0, 3'd0, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL pend_end: got %h want %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_abort;
        logic [15:0] got, exp;
        int d0;
        d0 = del_cnt;
        step;
        tx_send = 1'b1;
        tx_len  = 4'd4;
        step;
        tx_send = 1'b0;
        tx_len  = 4'd0;
        step;
        tx_byte_done = 1'b1;
        step;
        tx_byte_done = 1'b0;
        #1;
        got = {9'h0, state_o, tx_idx};
        exp = {9'h0, 3'd3, 4'd1};
        total_cnt++;
        if (got !== exp) $display("FAIL abort_load1: got %h want %h", got, exp);
        else pass_cnt++;
        step;
        tx_abort     = 1'b1;
        tx_byte_done = 1'b1;
        #1;
        got = {11'h0, state_o, tx_inprg, tx_data_cnt_delete};
        exp = {11'h0, 3'd4, 1'b0, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL abort_pulse: got %h want %h", got, exp);
        else pass_cnt++;
        step;
        tx_abort     = 1'b0;
        tx_byte_done = 1'b0;
        #1;
        got = {del_cnt - d0 == 1, 7'h0, state_o, tx_idx, tx_data_cnt_delete};
        exp = {1'b1, 7'h0, 3'd0, 4'd1, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL abort_after: got %h want %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_rx_err;
        logic [15:0] got, exp;
        step;
        rx_start = 1'b1;
        step;
        rx_start = 1'b0;
        rx_err   = 1'b1;
        rx_done  = 1'b1;
        step;
        rx_err   = 1'b0;
        rx_done  = 1'b0;
        #1;
        got = {12'h0, state_o, rx_err_flag};
        exp = {12'h0, 3'd5, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL rxerr_enter: got %h want %h", got, exp);
        else pass_cnt++;
        step;
        step;
        #1;
        got = {12'h0, state_o, rx_err_flag};
        exp = {12'h0, 3'd5, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL rxerr_hold: got %h want %h", got, exp);
        else pass_cnt++;
        rx_flag_clr = 1'b1;
        step;
        rx_flag_clr = 1'b0;
        #1;
        got = {12'h0, state_o, rx_err_flag};
        exp = {12'h0, 3'd0, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL rxerr_exit: got %h want %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_timeout;
        logic [15:0] got, exp;
        step;
        rx_start = 1'b1;
        step;
        rx_start = 1'b0;
        rx_done  = 1'b1;
        step;
        rx_done  = 1'b0;
        for (int w = 1; w <= 8; w++) begin
            if (w == 3) rx_start = 1'b1;
            #1;
            got = {11'h0, state_o, rx_overrun, rx_timeout};
            exp = {11'h0, 3'd2, (w > 3), 1'b0};
            total_cnt++;
            if (got !== exp) $display("FAIL tmo_wait w=%0d: got %h want %h", w, got, exp);
            else pass_cnt++;
            step;
            rx_start = 1'b0;
        end
        #1;
        got = {11'h0, state_o, rx_overrun, rx_timeout};
        exp = {11'h0, 3'd0, 1'b1, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL tmo_expire: got %h want %h", got, exp);
        else pass_cnt++;
        status_clr = 1'b1;
        step;
        status_clr = 1'b0;
        #1;
        got = {11'h0, state_o, rx_overrun, rx_timeout};
        exp = {11'h0, 3'd0, 1'b0, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL tmo_clear: got %h want %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_len_max;
        logic [15:0] got, exp;
        int r0, d0;
        r0 = req_cnt;
        d0 = del_cnt;
        step;
        tx_send = 1'b1;
        tx_len  = 4'hf;
        step;
        tx_send = 1'b0;
        tx_len  = 4'd0;
        for (int b = 0; b < 15; b++) begin
            #1;
            got = {8'h0, state_o, tx_byte_req, tx_idx};
            exp = {8'h0, 3'd3, 1'b1, 4'(b)};
            total_cnt++;
            if (got !== exp) $display("FAIL lenmax_load b=%0d: got %h want %h", b, got, exp);
            else pass_cnt++;
            step;
            tx_byte_done = 1'b1;
            #1;
            got = {15'h0, tx_data_cnt_delete};
            exp = {15'h0, (b == 14)};
            total_cnt++;
            if (got !== exp) $display("FAIL lenmax_done b=%0d: got %h want %h", b, got, exp);
            else pass_cnt++;
            step;
            tx_byte_done = 1'b0;
        end
        #1;
        got = {req_cnt - r0 == 15, del_cnt - d0 == 1, 7'h0, state_o, tx_idx};
        exp = {1'b1, 1'b1, 7'h0, 3'd0, 4'd14};
        total_cnt++;
        if (got !== exp) $display("FAIL lenmax_end: got %h want %h (req=%0d del=%0d)",
                                  got, exp, req_cnt - r0, del_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_zero_len;
        logic [15:0] got, exp;
        step;
        tx_send = 1'b1;
        tx_len  = 4'd0;
        step;
        tx_send = 1'b0;
        #1;
        got = {12'h0, state_o, tx_pend};
        exp = {12'h0, 3'd0, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL zero_idle: got %h want %h", got, exp);
        else pass_cnt++;
        rx_start = 1'b1;
        step;
        rx_start = 1'b0;
        tx_send  = 1'b1;
        step;
        tx_send  = 1'b0;
        #1;
        got = {12'h0, state_o, tx_pend};
        exp = {12'h0, 3'd1, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL zero_rx: got %h want %h", got, exp);
        else pass_cnt++;
        rx_err = 1'b1;
        step;
        rx_err      = 1'b0;
        rx_flag_clr = 1'b1;
        step;
        rx_flag_clr = 1'b0;
        #1;
        got = {13'h0, state_o};
        exp = {13'h0, 3'd0};
        total_cnt++;
        if (got !== exp) $display("FAIL zero_exit: got %h want %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [15:0] got, exp;
        int d0;
        d0 = del_cnt;
        step;
        tx_send = 1'b1;
        tx_len  = 4'd3;
        step;
        tx_send = 1'b0;
        tx_len  = 4'd0;
        step;
        tx_byte_done = 1'b1;
        step;
        tx_byte_done = 1'b0;
        step;
        #1;
        got = {8'h0, state_o, tx_idx, tx_inprg};
        exp = {8'h0, 3'd4, 4'd1, 1'b1};
        total_cnt++;
        if (got !== exp) $display("FAIL rstmid_pre: got %h want %h", got, exp);
        else pass_cnt++;
        #1;
        n_rst = 1'b0;
        #1;
        got = {3'b0, state_o, tx_idx, tx_pend, tx_byte_req, tx_inprg, tx_data_cnt_delete,
               rx_err_flag, rx_overrun, rx_timeout};
        exp = 16'h0;
        total_cnt++;
        if (got !== exp) $display("FAIL rstmid_async: got %h want %h", got, exp);
        else pass_cnt++;
        #2;
        n_rst = 1'b1;
        step;
        #1;
        got = {del_cnt - d0 == 0, 12'h0, state_o};
        exp = {1'b1, 12'h0, 3'd0};
        total_cnt++;
        if (got !== exp) $display("FAIL rstmid_after: got %h want %h (del=%0d)",
                                  got, exp, del_cnt - d0);
        else pass_cnt++;
    endtask

    initial begin
        n_rst        = 1'b0;
        tx_send      = 1'b0;
        tx_len       = '0;
        tx_byte_done = 1'b0;
        tx_abort     = 1'b0;
        rx_start     = 1'b0;
        rx_done      = 1'b0;
        rx_err       = 1'b0;
        rx_flag_clr  = 1'b0;
        status_clr   = 1'b0;
        test_reset;
        test_burst3;
        test_pend;
        test_abort;
        test_rx_err;
        test_timeout;
        test_len_max;
        test_zero_len;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
